fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end that replaces the free-running PC plus IF/ID register pair. It drives the synchronous instruction ROM, tracks one in-flight read, buffers returned instructions in a FIFO of configurable depth, and hands them to ID under a valid/ready handshake. It also adds backpressure (ID stall) and redirect (flush to a new PC), which the current front end lacks.

## Interface
- ADDR_WIDTH, 32, width of PC and ROM address
- INST_WIDTH, 32, width of instruction word
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- RESET_PC, 0, first fetch address; low 2 bits must be 0
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, asynchronous and active-low
- rom_en  out  1  ROM read request this cycle
- rom_addr  out  ADDR_WIDTH  ROM read address (current PC)
- rom_inst  in  INST_WIDTH  ROM data; valid exactly one cycle after a cycle with rom_en=1
- id_ready  in  1  ID accepts head entry this cycle
- inst_valid  out  1  head entry present
- inst_o  out  INST_WIDTH  head instruction
- addr_o  out  ADDR_WIDTH  address of head instruction
- flush  in  1  redirect request
- flush_target  in  ADDR_WIDTH  new PC on flush; bits [1:0] ignored (forced 0)

## Operation
- State: pc register, FIFO (inst + addr per entry), count (0..DEPTH), inflight bit, inflight_addr register.
- pop = inst_valid & id_ready & ~flush.
- Issue rule (combinational): rom_en = rst_n-released & ~flush & (count + inflight − pop < DEPTH). rom_addr = pc always.
- On issue: pc ← pc + 4 (modulo 2^ADDR_WIDTH; 0x…FFFC wraps to 0), inflight ← 1, inflight_addr ← pc. No issue: inflight ← 0.
- Return: when inflight=1 and no flush, push {rom_inst, inflight_addr} into FIFO at the edge ending that cycle.
- Push and pop in the same cycle allowed at any count, including full (count=DEPTH with return is impossible by issue rule) and empty (entry not bypassed; appears next cycle).
- inst_valid = (count ≠ 0). inst_o/addr_o = head entry when valid, all zeros when empty.
- Flush (priority over everything): count ← 0, inflight ← 0 (returning data that cycle discarded), pc ← {flush_target[ADDR_WIDTH-1:2], 2'b00}; rom_en=0 in the flush cycle; pop suppressed. Fetch resumes from target next cycle.
- Back-to-back flushes: last one wins; no fetch issued while flush held high.
- rom_inst ignored whenever inflight=0.

## Timing
- Reset (rst low, asynchronous): pc=RESET_PC, count=0, inflight=0, rom_en=0, rom_addr=RESET_PC, inst_valid=0, inst_o=0, addr_o=0. Reset asserted mid-stream discards FIFO and in-flight read immediately.
- Cycle 0 after rst release: rom_en=1, rom_addr=RESET_PC. Cycle 1: rom_inst returned, pushed at cycle-1 edge. Cycle 2: inst_valid=1, addr_o=RESET_PC. Request-to-head latency 2 cycles.
- Steady state with id_ready=1: one instruction per cycle, addresses consecutive +4, no bubbles.
- id_ready=0: FIFO fills; rom_en deasserts when count + inflight reaches DEPTH; head held stable (inst_o/addr_o unchanged) while inst_valid=1 and id_ready=0.
- After flush in cycle F: rom_en=1 with rom_addr=target in F+1; target at head in F+3.

## Test plan
- Reset/stream: DEPTH=4, RESET_PC=0, ROM returns addr as data, id_ready=1 -> rom_addr 0,4,8,… from cycle 0; inst_valid first high cycle 2; addr_o 0,4,8,… one per cycle, inst_o == addr_o.
- Backpressure: id_ready=0 from cycle 0 -> exactly 4 requests (0,4,8,C), rom_en low from cycle 4; count=4; head addr_o=0 stable; raise id_ready -> pops 0,4,8,C,10,… with no gap and no duplicate/skip.
- Flush with in-flight read: stream running, flush=1 with flush_target=0x103 while inflight=1 -> inst_valid=0 next cycle, discarded data never appears, rom_addr=0x100 in F+1, addr_o=0x100 in F+3.
- Simultaneous pop at full: fill to 4 with id_ready=0, then id_ready=1 for one cycle -> one pop and one new issue same cycle; count remains ≤ 4, order preserved.
- PC wrap: RESET_PC=0xFFFFFFF8 -> addr_o sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Mid-stream reset: assert rst low between edges during streaming -> rom_en, inst_valid, inst_o, addr_o zero immediately (asynchronous), rom_addr=RESET_PC; after release sequence restarts as in first scenario.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: ROM request issue, one in-flight read,
// a FIFO of returned instructions and a valid/ready hand-off to ID.
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [INST_WIDTH-1:0] rom_inst,
  input  logic                  id_ready,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_target
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_addr;
  logic                  inflight;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];

  logic          push;
  logic          pop;
  logic [CW:0]   occ;

  assign push = inflight & ~flush;
  assign pop  = inst_valid & id_ready & ~flush;

  // Occupancy after this cycle's pop, counting the read still in flight.
  assign occ = {1'b0, count}
             + {{CW{1'b0}}, inflight}
             - {{CW{1'b0}}, pop};

  assign rom_en   = rst & ~flush & (occ < (CW+1)'(DEPTH));
  assign rom_addr = pc;

  assign inst_valid = (count != '0);
  assign inst_o = inst_valid ? inst_mem[rd_ptr] : '0;
  assign addr_o = inst_valid ? addr_mem[rd_ptr] : '0;

  // PC, in-flight tracking and FIFO bookkeeping; flush overrides all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else if (flush) begin
      pc       <= flush_target & ~ADDR_WIDTH'(3);
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= rom_en;
      if (rom_en) begin
        pc            <= pc + ADDR_WIDTH'(4);
        inflight_addr <= pc;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{PW{1'b0}}, push}
             - {{PW{1'b0}}, pop};
    end
  end

  // FIFO storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= rom_inst;
      addr_mem[wr_ptr] <= inflight_addr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, flush,
// pop at full, PC wrap and asynchronous mid-stream reset.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_ready = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_target = '0;

  logic        a_en, a_valid;
  logic [31:0] a_addr, a_inst, a_io, a_ao;
  logic        b_en, b_valid;
  logic [31:0] b_addr, b_inst, b_io, b_ao;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // ROM models: data is the address, one cycle after the request.
  always @(posedge clk) a_inst <= a_addr;
  always @(posedge clk) b_inst <= b_addr;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .rst(rst),
    .rom_en(a_en), .rom_addr(a_addr), .rom_inst(a_inst),
    .id_ready(id_ready),
    .inst_valid(a_valid), .inst_o(a_io), .addr_o(a_ao),
    .flush(flush), .flush_target(flush_target)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst),
    .rom_en(b_en), .rom_addr(b_addr), .rom_inst(b_inst),
    .id_ready(1'b1),
    .inst_valid(b_valid), .inst_o(b_io), .addr_o(b_ao),
    .flush(1'b0), .flush_target(32'h0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    #1;
    chk("rst_en", {31'b0, a_en}, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_valid", {31'b0, a_valid}, 0);
    chk("rst_inst", a_io, 0);
    chk("rst_addro", a_ao, 0);
    chk("rst_b_addr", b_addr, 32'hFFFF_FFF8);

    // stream: release at this point is cycle 0
    rst = 1'b1;
    #1;
    chk("c0_en", {31'b0, a_en}, 1);
    chk("c0_addr", a_addr, 0);
    for (int k = 1; k <= 8; k++) begin
      nxt();
      chk("st_addr", a_addr, 32'(4 * k));
      chk("st_en", {31'b0, a_en}, 1);
      if (k == 1) begin
        chk("st_valid1", {31'b0, a_valid}, 0);
      end else begin
        chk("st_valid", {31'b0, a_valid}, 1);
        chk("st_addro", a_ao, 32'(4 * (k - 2)));
        chk("st_inst", a_io, 32'(4 * (k - 2)));
      end
      if (k == 2) chk("wrap0", b_ao, 32'hFFFF_FFF8);
      if (k == 3) chk("wrap1", b_ao, 32'hFFFF_FFFC);
      if (k == 4) chk("wrap2", b_ao, 32'h0);
      if (k == 5) chk("wrap3", b_ao, 32'h4);
    end

    // flush with a read in flight (cycle F)
    @(negedge clk);
    flush = 1'b1;
    flush_target = 32'h103;
    #1;
    chk("f_en", {31'b0, a_en}, 0);
    nxt();
    flush = 1'b0;
    #0;
    chk("f1_valid", {31'b0, a_valid}, 0);
    chk("f1_en", {31'b0, a_en}, 1);
    chk("f1_addr", a_addr, 32'h100);
    nxt();
    chk("f2_valid", {31'b0, a_valid}, 0);
    chk("f2_addr", a_addr, 32'h104);
    nxt();
    chk("f3_valid", {31'b0, a_valid}, 1);
    chk("f3_addro", a_ao, 32'h100);
    chk("f3_inst", a_io, 32'h100);
    nxt();
    chk("f4_addro", a_ao, 32'h104);

    // asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk("ar_en", {31'b0, a_en}, 0);
    chk("ar_valid", {31'b0, a_valid}, 0);
    chk("ar_inst", a_io, 0);
    chk("ar_addro", a_ao, 0);
    chk("ar_addr", a_addr, 0);
    chk("ar_b_valid", {31'b0, b_valid}, 0);

    // restart under backpressure
    @(negedge clk);
    id_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("bp0_en", {31'b0, a_en}, 1);
    chk("bp0_addr", a_addr, 0);
    nxt();
    chk("bp1_addr", a_addr, 32'h4);
    nxt();
    chk("bp2_addr", a_addr, 32'h8);
    chk("bp2_valid", {31'b0, a_valid}, 1);
    chk("bp2_addro", a_ao, 0);
    chk("bp2_b_addro", b_ao, 32'hFFFF_FFF8);
    nxt();
    chk("bp3_en", {31'b0, a_en}, 1);
    chk("bp3_addr", a_addr, 32'hC);
    for (int k = 4; k <= 6; k++) begin
      nxt();
      chk("bp_en_low", {31'b0, a_en}, 0);
      chk("bp_hold", a_ao, 0);
      chk("bp_hold_i", a_io, 0);
    end

    // one-cycle pop at full: pop and issue together
    @(negedge clk);
    id_ready = 1'b1;
    #1;
    chk("pf_en", {31'b0, a_en}, 1);
    chk("pf_addr", a_addr, 32'h10);
    chk("pf_addro", a_ao, 0);
    @(negedge clk);
    id_ready = 1'b0;
    #1;
    chk("pf1_en", {31'b0, a_en}, 0);
    chk("pf1_addro", a_ao, 32'h4);
    nxt();
    chk("pf2_en", {31'b0, a_en}, 0);
    chk("pf2_addro", a_ao, 32'h4);

    // drain: no gap, no duplicate, no skip
    @(negedge clk);
    id_ready = 1'b1;
    #1;
    chk("dr_en", {31'b0, a_en}, 1);
    chk("dr_addr", a_addr, 32'h14);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) nxt();
      chk("dr_valid", {31'b0, a_valid}, 1);
      chk("dr_addro", a_ao, 32'(4 + 4 * j));
      chk("dr_inst", a_io, 32'(4 + 4 * j));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
